// File: rtl/carfield_mailbox_pkg.sv
// Shared types and register offsets for the Carfield mailbox responder.
package carfield_mailbox_pkg;

    localparam int unsigned DataW       = 32;
    localparam int unsigned StrbW       = DataW / 8;
    localparam int unsigned AddrW       = 48;
    localparam int unsigned MaxMsgWords = 4;
    localparam int unsigned IrqEnW      = 3;
    localparam int unsigned MboxStride  = 'h20;

    localparam logic [4:0] MsgOff        = 5'h00;
    localparam logic [4:0] DoorbellOff   = 5'h10;
    localparam logic [4:0] CompletionOff = 5'h14;
    localparam logic [4:0] IrqEnOff      = 5'h18;
    localparam logic [4:0] StatusOff     = 5'h1C;

    typedef enum logic [2:0] {
        REG_MSG,
        REG_DOORBELL,
        REG_COMPLETION,
        REG_IRQ_EN,
        REG_STATUS
    } reg_e;

    typedef struct packed {
        logic [MaxMsgWords-1:0][DataW-1:0] msg;
        logic                              doorbell;
        logic                              completion;
        logic                              timeout;
        logic [IrqEnW-1:0]                 irq_en;
    } mbox_state_t;

    typedef enum logic {
        IDLE,
        RESP
    } fsm_e;

    // Expand byte strobes into a bit mask.
    function automatic logic [DataW-1:0] strb_mask(input logic [StrbW-1:0] strb);
        logic [DataW-1:0] mask;
        for (int b = 0; b < int'(StrbW); b++) begin
            mask[b*8 +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/carfield_mailbox_unit.sv
// One mailbox: message words, doorbell/completion flags, IRQ enables and write protection.
// Optional doorbell-pending timeout counter enabled by CARFIELD_MBOX_TIMEOUT_EN.
module carfield_mailbox_unit
    import carfield_mailbox_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_en_i,
    input  reg_e                kind_i,
    input  logic [1:0]          msg_idx_i,
    input  logic [DataW-1:0]    wdata_i,
    input  logic [StrbW-1:0]    wstrb_i,
    output mbox_state_t         state_o,
    output logic                wr_err_c_o
);

    mbox_state_t      st_q, st_d;
    logic [DataW-1:0] mask_c;
    logic [DataW-1:0] wd_c;
    logic             wr_err_c;

`ifdef CARFIELD_MBOX_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_c;
    assign unused_timeout_c = ^32'(TimeoutCycles);
`endif

    assign mask_c = strb_mask(wstrb_i);
    assign wd_c   = wdata_i & mask_c;

    // Write protection: message is frozen and doorbell cannot re-ring while pending.
    always_comb begin
        wr_err_c = 1'b0;
        case (kind_i)
            REG_MSG:      wr_err_c = st_q.doorbell;
            REG_DOORBELL: wr_err_c = wd_c[0] && st_q.doorbell;
            default:      wr_err_c = 1'b0;
        endcase
    end

    always_comb begin
        st_d = st_q;
`ifdef CARFIELD_MBOX_TIMEOUT_EN
        cnt_d = cnt_q;
`endif
        if (wr_en_i && !wr_err_c) begin
            case (kind_i)
                REG_MSG: begin
                    st_d.msg[msg_idx_i] = (st_q.msg[msg_idx_i] & ~mask_c) | wd_c;
                end
                REG_DOORBELL: begin
                    if (wd_c[0]) st_d.doorbell = 1'b1;
                end
                REG_COMPLETION: begin
                    // Clear first so a simultaneous set wins.
                    if (wd_c[1]) st_d.completion = 1'b0;
                    if (wd_c[0] && st_q.doorbell) begin
                        st_d.doorbell   = 1'b0;
                        st_d.completion = 1'b1;
                    end
                end
                REG_IRQ_EN: begin
                    st_d.irq_en = wd_c[IrqEnW-1:0];
                end
                default: ;
            endcase
        end
`ifdef CARFIELD_MBOX_TIMEOUT_EN
        if (!st_d.doorbell) begin
            cnt_d        = '0;
            st_d.timeout = 1'b0;
        end else if (st_q.doorbell && (cnt_q != CntW'(TimeoutCycles))) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_d == CntW'(TimeoutCycles)) st_d.timeout = 1'b1;
        end
`else
        st_d.timeout = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

`ifdef CARFIELD_MBOX_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign state_o    = st_q;
    assign wr_err_c_o = wr_err_c;

endmodule

// File: rtl/carfield_mailbox_responder.sv
// Register-bus responder for the mailbox window: decode, IDLE/RESP handshake, response mux.
// Optional timeout IRQs enabled by CARFIELD_MBOX_TIMEOUT_EN.
module carfield_mailbox_responder
    import carfield_mailbox_pkg::*;
#(
    parameter int unsigned       NumMbox       = 4,
    parameter int unsigned       MsgWords      = 2,
    parameter logic [AddrW-1:0]  MboxBase      = 48'h0000_4000_0000,
    parameter logic [AddrW-1:0]  MboxSize      = 48'h0000_0000_1000,
    parameter int unsigned       TimeoutCycles = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    input  logic [AddrW-1:0]    req_addr_i,
    input  logic                req_write_i,
    input  logic [DataW-1:0]    req_wdata_i,
    input  logic [StrbW-1:0]    req_wstrb_i,
    output logic                rsp_ready_o,
    output logic [DataW-1:0]    rsp_rdata_o,
    output logic                rsp_error_o,
    output logic [NumMbox-1:0]  doorbell_irq_o,
    output logic [NumMbox-1:0]  completion_irq_o,
    output logic [NumMbox-1:0]  timeout_irq_o
);

    localparam int unsigned IdxW = AddrW - 5;

    fsm_e             state_q, state_d;
    logic             rsp_ready_q, rsp_ready_d;
    logic             rsp_error_q, rsp_error_d;
    logic [DataW-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [AddrW-1:0] offset_c;
    logic [IdxW-1:0]  mbox_idx_c;
    logic [4:0]       reg_off_c;
    logic [1:0]       msg_idx_c;
    reg_e             kind_c;
    logic             dec_err_c;
    logic             access_c;

    mbox_state_t      mbox_state [NumMbox];
    logic [NumMbox-1:0] wr_en_c;
    logic [NumMbox-1:0] wr_err_c;
    mbox_state_t      sel_state_c;
    logic             sel_wr_err_c;
    logic [DataW-1:0] rd_data_c;

    // Address decode into mailbox index, register kind and message word.
    always_comb begin
        offset_c   = req_addr_i - MboxBase;
        mbox_idx_c = offset_c[AddrW-1:5];
        reg_off_c  = offset_c[4:0];
        msg_idx_c  = 2'((reg_off_c ^ MsgOff) >> 2);
        case (reg_off_c)
            DoorbellOff:   kind_c = REG_DOORBELL;
            CompletionOff: kind_c = REG_COMPLETION;
            IrqEnOff:      kind_c = REG_IRQ_EN;
            StatusOff:     kind_c = REG_STATUS;
            default:       kind_c = REG_MSG;
        endcase
        dec_err_c = (req_addr_i < MboxBase)
                 || (req_addr_i >= (MboxBase + MboxSize))
                 || (req_addr_i[1:0] != 2'b00)
                 || (mbox_idx_c >= IdxW'(NumMbox))
                 || ((kind_c == REG_MSG) && (32'(msg_idx_c) >= MsgWords))
                 || ((kind_c == REG_STATUS) && req_write_i);
    end

    assign access_c = (state_q == IDLE) && req_valid_i;

    for (genvar i = 0; i < int'(NumMbox); i++) begin : g_unit
        assign wr_en_c[i] = access_c && req_write_i && !dec_err_c && (mbox_idx_c == IdxW'(i));

        carfield_mailbox_unit #(
            .TimeoutCycles (TimeoutCycles)
        ) u_unit (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .wr_en_i    (wr_en_c[i]),
            .kind_i     (kind_c),
            .msg_idx_i  (msg_idx_c),
            .wdata_i    (req_wdata_i),
            .wstrb_i    (req_wstrb_i),
            .state_o    (mbox_state[i]),
            .wr_err_c_o (wr_err_c[i])
        );
    end

    // Select the addressed mailbox and format its read data.
    always_comb begin
        sel_state_c  = '0;
        sel_wr_err_c = 1'b0;
        for (int i = 0; i < int'(NumMbox); i++) begin
            if (mbox_idx_c == IdxW'(i)) begin
                sel_state_c  = mbox_state[i];
                sel_wr_err_c = wr_err_c[i];
            end
        end
        case (kind_c)
            REG_MSG:        rd_data_c = sel_state_c.msg[msg_idx_c];
            REG_DOORBELL:   rd_data_c = DataW'(sel_state_c.doorbell);
            REG_COMPLETION: rd_data_c = DataW'(sel_state_c.completion);
            REG_IRQ_EN:     rd_data_c = DataW'(sel_state_c.irq_en);
            REG_STATUS:     rd_data_c = DataW'({sel_state_c.timeout, sel_state_c.completion,
                                                sel_state_c.doorbell});
            default:        rd_data_c = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rsp_ready_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    state_d     = RESP;
                    rsp_ready_d = 1'b1;
                    rsp_error_d = dec_err_c || (req_write_i && sel_wr_err_c);
                    if (!req_write_i && !dec_err_c) rsp_rdata_d = rd_data_c;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rsp_ready_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rsp_ready_q <= rsp_ready_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_ready_o = rsp_ready_q;
    assign rsp_error_o = rsp_error_q;
    assign rsp_rdata_o = rsp_rdata_q;

    // Interrupts are flag AND enable, straight from the mailbox registers.
    always_comb begin
        for (int i = 0; i < int'(NumMbox); i++) begin
            doorbell_irq_o[i]   = mbox_state[i].doorbell   && mbox_state[i].irq_en[0];
            completion_irq_o[i] = mbox_state[i].completion && mbox_state[i].irq_en[1];
            timeout_irq_o[i]    = mbox_state[i].timeout    && mbox_state[i].irq_en[2];
        end
    end

endmodule

// File: tb/tb_carfield_mailbox_responder.sv
// Randomized self-checking bench for carfield_mailbox_responder against a behavioural mailbox model.
module tb_carfield_mailbox_responder;

    localparam int unsigned N    = 4;
    localparam int unsigned MW   = 2;
    localparam int unsigned TO   = 16;
    localparam logic [47:0] BASE = 48'h0000_4000_0000;
    localparam logic [47:0] SIZE = 48'h0000_0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [47:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [N-1:0] db_irq, cmp_irq, to_irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_msg [N][MW];
    logic        m_db  [N];
    logic        m_cmp [N];
    logic [2:0]  m_en  [N];

    logic [31:0] last_rd;
    logic        last_err;
    logic [N-1:0] last_db_irq, last_cmp_irq, last_to_irq;

    carfield_mailbox_responder #(
        .NumMbox       (N),
        .MsgWords      (MW),
        .MboxBase      (BASE),
        .MboxSize      (SIZE),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_addr_i       (req_addr),
        .req_write_i      (req_write),
        .req_wdata_i      (req_wdata),
        .req_wstrb_i      (req_wstrb),
        .rsp_ready_o      (rsp_ready),
        .rsp_rdata_o      (rsp_rdata),
        .rsp_error_o      (rsp_error),
        .doorbell_irq_o   (db_irq),
        .completion_irq_o (cmp_irq),
        .timeout_irq_o    (to_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%08h expected=%08h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) begin
            for (int k = 0; k < int'(MW); k++) m_msg[i][k] = '0;
            m_db[i]  = 1'b0;
            m_cmp[i] = 1'b0;
            m_en[i]  = '0;
        end
    endtask

    // Applies one access to the model; returns expected rdata/error and a compare mask.
    task automatic model_xfer(input logic [47:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] s, output logic [31:0] rd,
                              output logic er, output logic [31:0] rmask);
        logic [31:0] m, dm;
        logic [47:0] off;
        int mb, r, k;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        dm = d & m;
        rd = '0;
        er = 1'b0;
        rmask = 32'hFFFF_FFFF;
        if (a < BASE || a >= BASE + SIZE || (a % 4) != 0) begin
            er = 1'b1;
        end else begin
            off = a - BASE;
            mb  = int'(off / 32);
            r   = int'(off % 32);
            if (mb >= int'(N)) begin
                er = 1'b1;
            end else if (r < 16) begin
                k = r / 4;
                if (k >= int'(MW)) er = 1'b1;
                else if (!w) rd = m_msg[mb][k];
                else if (m_db[mb]) er = 1'b1;
                else m_msg[mb][k] = (m_msg[mb][k] & ~m) | dm;
            end else if (r == 16) begin
                if (!w) rd = {31'b0, m_db[mb]};
                else if (dm[0] && m_db[mb]) er = 1'b1;
                else if (dm[0]) m_db[mb] = 1'b1;
            end else if (r == 20) begin
                if (!w) rd = {31'b0, m_cmp[mb]};
                else begin
                    if (dm[1]) m_cmp[mb] = 1'b0;
                    if (dm[0] && m_db[mb]) begin
                        m_db[mb]  = 1'b0;
                        m_cmp[mb] = 1'b1;
                    end
                end
            end else if (r == 24) begin
                if (!w) rd = {29'b0, m_en[mb]};
                else m_en[mb] = dm[2:0];
            end else begin
                if (w) er = 1'b1;
                else rd = {30'b0, m_cmp[mb], m_db[mb]};
`ifdef CARFIELD_MBOX_TIMEOUT_EN
                rmask = 32'hFFFF_FFFB;
`endif
            end
        end
    endtask

    // One bus access: drive, check 1-cycle latency, compare against model, check single-cycle ready.
    task automatic xfer(input logic [47:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] exp_rd, rmask;
        logic exp_err;
        logic [N-1:0] exp_db, exp_cmp;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        req_wstrb = s;
        model_xfer(a, w, d, s, exp_rd, exp_err, rmask);
        for (int i = 0; i < int'(N); i++) begin
            exp_db[i]  = m_db[i] & m_en[i][0];
            exp_cmp[i] = m_cmp[i] & m_en[i][1];
        end
        @(posedge clk);
        #1;
        last_rd      = rsp_rdata;
        last_err     = rsp_error;
        last_db_irq  = db_irq;
        last_cmp_irq = cmp_irq;
        last_to_irq  = to_irq;
        check("ready_latency", 32'(rsp_ready), 32'd1);
        check("rdata", rsp_rdata & rmask, exp_rd & rmask);
        check("error", 32'(rsp_error), 32'(exp_err));
        check("doorbell_irq", 32'(db_irq), 32'(exp_db));
        check("completion_irq", 32'(cmp_irq), 32'(exp_cmp));
`ifndef CARFIELD_MBOX_TIMEOUT_EN
        check("timeout_irq", 32'(to_irq), 32'd0);
`endif
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("ready_single", 32'(rsp_ready), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int sel, mb, r;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        req_wstrb = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(rsp_ready), 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_error", 32'(rsp_error), 32'd0);
        check("reset_irqs", 32'({db_irq, cmp_irq, to_irq}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Message write and readback on mbox1
        xfer(BASE + 48'h20, 1'b1, 32'hDEAD_BEEF, 4'hF);
        check("msg_wr_err", 32'(last_err), 32'd0);
        xfer(BASE + 48'h20, 1'b0, 32'h0, 4'h0);
        check("msg_rd_val", last_rd, 32'hDEAD_BEEF);
        // Doorbell with IRQ, overflow and protected message
        xfer(BASE + 48'h38, 1'b1, 32'h1, 4'hF);
        xfer(BASE + 48'h30, 1'b1, 32'h1, 4'hF);
        check("db_irq_set", 32'(last_db_irq[1]), 32'd1);
        xfer(BASE + 48'h30, 1'b1, 32'h1, 4'hF);
        check("db_overflow", 32'(last_err), 32'd1);
        xfer(BASE + 48'h20, 1'b1, 32'h1234_5678, 4'hF);
        check("msg_protect_err", 32'(last_err), 32'd1);
        xfer(BASE + 48'h20, 1'b0, 32'h0, 4'h0);
        check("msg_protect_val", last_rd, 32'hDEAD_BEEF);
        // Completion handshake
        xfer(BASE + 48'h38, 1'b1, 32'h3, 4'hF);
        xfer(BASE + 48'h34, 1'b1, 32'h1, 4'hF);
        check("cmp_db_clear", 32'(last_db_irq[1]), 32'd0);
        check("cmp_irq_set", 32'(last_cmp_irq[1]), 32'd1);
        xfer(BASE + 48'h34, 1'b1, 32'h2, 4'hF);
        check("cmp_irq_clear", 32'(last_cmp_irq[1]), 32'd0);
        // Set and clear in one write: set wins
        xfer(BASE + 48'h50, 1'b1, 32'h1, 4'hF);
        xfer(BASE + 48'h54, 1'b1, 32'h3, 4'hF);
        xfer(BASE + 48'h5C, 1'b0, 32'h0, 4'h0);
        check("set_wins_status", last_rd & 32'h3, 32'h2);
        // Decode errors
        xfer(BASE + 48'h1000, 1'b0, 32'h0, 4'h0);
        check("oow_err", {31'b0, last_err} | (last_rd << 1), 32'd1);
        xfer(BASE + 48'h2, 1'b0, 32'h0, 4'h0);
        check("misalign_err", {31'b0, last_err} | (last_rd << 1), 32'd1);
        xfer(BASE + 48'hA0, 1'b0, 32'h0, 4'h0);
        check("idx_err", {31'b0, last_err} | (last_rd << 1), 32'd1);
        xfer(BASE + 48'h08, 1'b0, 32'h0, 4'h0);
        check("msgidx_err", 32'(last_err), 32'd1);
        xfer(BASE + 48'h1C, 1'b1, 32'h7, 4'hF);
        check("status_wr_err", 32'(last_err), 32'd1);

`ifdef CARFIELD_MBOX_TIMEOUT_EN
        // Doorbell left pending raises the timeout IRQ; completion clears it
        xfer(BASE + 48'h18, 1'b1, 32'h4, 4'hF);
        xfer(BASE + 48'h10, 1'b1, 32'h1, 4'hF);
        check("to_not_yet", 32'(last_to_irq[0]), 32'd0);
        repeat (TO + 4) @(posedge clk);
        #1;
        check("to_irq_set", 32'(to_irq[0]), 32'd1);
        xfer(BASE + 48'h14, 1'b1, 32'h1, 4'hF);
        check("to_irq_clear", 32'(last_to_irq[0]), 32'd0);
`endif

        // Randomized accesses against the model
        for (int it = 0; it < 400; it++) begin
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                a = BASE + SIZE + 48'(4 * $urandom_range(0, 15));
            end else if (sel == 1) begin
                a = BASE - 48'd4;
            end else begin
                mb = int'($urandom_range(0, N + 1));
                r  = 4 * int'($urandom_range(0, 7));
                a  = BASE + 48'(mb * 32 + r);
                if (sel == 2) a = a + 48'($urandom_range(1, 3));
            end
            r = int'((a - BASE) % 32);
            if (r >= 16 && r < 28) d = 32'($urandom_range(0, 7));
            else d = $urandom;
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            xfer(a, 1'($urandom), d, s);
        end

        // Reset dropped during RESP of a doorbell write
        xfer(BASE + 48'h78, 1'b1, 32'h1, 4'hF);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = BASE + 48'h70;
        req_write = 1'b1;
        req_wdata = 32'h1;
        req_wstrb = 4'hF;
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("rst_no_ready", 32'(rsp_ready), 32'd0);
        check("rst_irqs", 32'({db_irq, cmp_irq, to_irq}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_ready", 32'(rsp_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < int'(N); i++) begin
            xfer(BASE + 48'(i * 32 + 28), 1'b0, 32'h0, 4'h0);
            check("rst_status", last_rd, 32'd0);
        end
        xfer(BASE + 48'h78, 1'b0, 32'h0, 4'h0);
        check("rst_irq_en", last_rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/carfield_mailbox_responder.md
Name: carfield_mailbox_responder

Overview:
- Register-bus responder behind the Mailbox window: base 0x4000_0000, size 0x1000.
- Holds NumMbox mailboxes. Each mailbox has message words, a doorbell, a completion flag and IRQ enables.
- An initiator (host or island) writes a message and rings the doorbell. The receiver reads it and acknowledges via the completion register.
- Doorbell and completion interrupts go to the respective cores.

Parameters:
NumMbox, 4, number of mailboxes (1..16)
MsgWords, 2, 32-bit message words per mailbox (1..4)
MboxBase, 'h40000000, absolute base address of the window
MboxSize, 'h00001000, window size in bytes
TimeoutCycles, 1024, doorbell-pending cycles before timeout IRQ (optional feature only)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_addr_i  in  48  byte address
req_write_i  in  1  1=write, 0=read
req_wdata_i  in  32  write data
req_wstrb_i  in  4  byte strobes
rsp_ready_o  out  1  response/accept pulse
rsp_rdata_o  out  32  read data
rsp_error_o  out  1  access error
doorbell_irq_o  out  NumMbox  doorbell pending & enabled
completion_irq_o  out  NumMbox  completion pending & enabled
timeout_irq_o  out  NumMbox  timeout flag (tied 0 without feature)

Behaviour:
- Clock and reset: one clock (clk_i); asynchronous active-low reset (rst_ni).
- Reset values: all outputs 0; all registers 0; FSM in IDLE.
- Register map per mailbox, stride 0x20 at offset i*0x20:
  - 0x00+4k: MSG[k], RW, k<MsgWords.
  - 0x10: DOORBELL. Write bit0=1 sets pending; write 0 is a no-op.
  - 0x14: COMPLETION. Write bit0=1 clears the doorbell and sets the completion flag. Write bit1=1 clears the completion flag.
  - 0x18: IRQ_EN. bit0 doorbell, bit1 completion, bit2 timeout.
  - 0x1C: STATUS, RO. {timeout, completion, doorbell}.
- FSM IDLE/RESP:
  - IDLE: on req_valid_i, latch the request, perform decode and register update, go to RESP.
  - RESP: assert rsp_ready_o for exactly one cycle with rdata/error, return to IDLE.
  - Latency: ready is asserted the cycle after valid is sampled. Max throughput is one access per 2 cycles.
  - The initiator must hold the request until ready; the responder ignores the held request during RESP.
- Decode:
  - Offset = addr - MboxBase.
  - Error (rdata=0, no state change) when:
    - addr is outside [MboxBase, MboxBase+MboxSize);
    - addr is not word-aligned;
    - mailbox index >= NumMbox;
    - offset is unmapped;
    - MSG index >= MsgWords;
    - the access writes STATUS.
- Data writes: apply wstrb bytewise. Reads ignore wstrb.
- Protection rules:
  - A MSG write while doorbell is pending returns an error and leaves the message unchanged.
  - A DOORBELL write while doorbell is already pending returns an error (overflow).
  - A COMPLETION bit0 write with no doorbell pending is a no-op, not an error.
- IRQs: each IRQ = flag & enable, combinational from registers. A flag set this access is visible on the IRQ output in the RESP cycle.
- Simultaneous COMPLETION bit0 and bit1 in one write: the doorbell clears, and the completion flag ends set (set wins).
- Reset mid-transaction: FSM returns to IDLE, no response is issued, all state is cleared.

Optional Feature:
- Macro: CARFIELD_MBOX_TIMEOUT_EN.
- With the macro:
  - Each mailbox has a $clog2(TimeoutCycles+1)-bit counter.
  - The counter increments each cycle while doorbell is pending and saturates at TimeoutCycles.
  - When it reaches TimeoutCycles, the timeout flag sets.
  - Doorbell clear resets the counter and clears the timeout flag.
  - A write to STATUS... is still an error; timeout is cleared only via completion.
- Without the macro: no counters; timeout_irq_o = 0; STATUS bit2 reads 0; IRQ_EN bit2 is RW but has no effect.

Decomposition:
- Package carfield_mailbox_pkg holds:
  - register offset localparams (MsgOff, DoorbellOff, CompletionOff, IrqEnOff, StatusOff, MboxStride = 'h20);
  - mbox_state_t struct {msg, doorbell, completion, timeout, irq_en};
  - fsm_e enum {IDLE, RESP}.
- Sub-module carfield_mailbox_unit: one instance per mailbox, containing the state, protection logic and optional timeout counter. The top handles decode, the FSM and response muxing.

Test Plan:
- Write MSG0 of mbox1 (0x4000_0020) = 0xDEAD_BEEF, then read back -> rdata 0xDEAD_BEEF, error=0, ready exactly 1 cycle after valid.
- Enable doorbell IRQ (0x38 = 1), write DOORBELL (0x30 = 1) -> doorbell_irq_o[1]=1 in RESP cycle. A second DOORBELL write -> error=1. A MSG0 write -> error=1, value stays 0xDEAD_BEEF.
- Enable completion IRQ (0x38 = 3), write COMPLETION 0x34 = 1 -> doorbell_irq_o[1]=0, completion_irq_o[1]=1. Write 0x34 = 2 -> completion_irq_o[1]=0.
- Read 0x4000_1000, 0x4000_0002 and mbox index 5 (0x4000_00A0) -> each error=1, rdata=0.
- With CARFIELD_MBOX_TIMEOUT_EN and TimeoutCycles=16: ring mbox0 with timeout IRQ enabled, wait 16 cycles -> timeout_irq_o[0]=1. Complete -> timeout_irq_o[0]=0.
- Drop rst_ni during RESP after a DOORBELL write -> no ready, all IRQs 0, STATUS reads 0 after reset.
